pwm_speed_sequencer: RTL

- Soft-start/soft-stop controller placed in front of the PWM generator.
- Decodes the operator's 7-bit active-low speed switches into a target level (0..7).
- Ramps the applied level one step at a time, every RAMP_TICKS cycles, and drives the PWM generator's 7-bit active-low speed code.
- Provides emergency stop with a latched fault that needs an operator "off" before restart.

---
 rtl/pwm_speed_sequencer.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/pwm_speed_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pwm_speed_sequencer
// Brief    : Soft-start/soft-stop level sequencer in front of a PWM generator.
//            Optional step alignment to PWM period boundaries: SEQ_PERIOD_ALIGN_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_speed_sequencer #(
    parameter int RAMP_TICKS = 1000,
    parameter int PERIOD     = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] switch_in,
    input  logic       estop,
    output logic [6:0] speed_switch,
    output logic [2:0] level,
    output logic       busy,
    output logic       fault,
    output logic       sw_err
);

    localparam int TW = $clog2(RAMP_TICKS);
    localparam logic [TW-1:0] C_TIMER_LAST = TW'(RAMP_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_HOLD      = 3'd1,
        S_RAMP_UP   = 3'd2,
        S_RAMP_DOWN = 3'd3,
        S_ESTOP     = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [6:0]      sw_q, sw_d;
    logic [2:0]      target_q, target_d;
    logic [2:0]      level_q, level_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [6:0]      speed_switch_q, speed_switch_d;
    logic            busy_q, busy_d;
    logic            fault_q, fault_d;
    logic            sw_err_q, sw_err_d;
    logic            w_timer_tc;
    logic            w_step_ok;

    function automatic logic sw_valid(input logic [6:0] s);
        int zeros;
        zeros = 0;
        for (int i = 0; i < 7; i++) begin
            if (!s[i]) zeros++;
        end
        return (zeros <= 1);
    endfunction

    // Caller guarantees the pattern is valid (off or single zero).
    function automatic logic [2:0] sw_decode(input logic [6:0] s);
        logic [2:0] t;
        t = 3'd0;
        for (int i = 0; i < 7; i++) begin
            if (!s[i]) t = 3'(i + 1);
        end
        return t;
    endfunction

    function automatic logic [6:0] encode(input logic [2:0] l);
        logic [6:0] e;
        e = 7'h7F;
        if (l != 3'd0) e[l - 3'd1] = 1'b0;
        return e;
    endfunction

`ifdef SEQ_PERIOD_ALIGN_EN
    localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    logic [PW-1:0] pcnt_q, pcnt_d;

    always_comb begin
        pcnt_d = (pcnt_q == PW'(PERIOD - 1)) ? '0 : PW'(pcnt_q + 1'b1);
    end

    always_ff @(posedge clk) begin
        if (!rst) pcnt_q <= '0;
        else      pcnt_q <= pcnt_d;
    end

    // A due step waits here (timer parked at terminal count) until the period ends.
    assign w_step_ok = (pcnt_q == PW'(PERIOD - 1));
`else
    // Without alignment every terminal count is a step opportunity.
    assign w_step_ok = (PERIOD != 0);
`endif

    assign w_timer_tc = (timer_q == C_TIMER_LAST);

    always_comb begin
        sw_d     = switch_in;
        sw_err_d = (switch_in != sw_q) && !sw_valid(switch_in);
        target_d = sw_valid(sw_q) ? sw_decode(sw_q) : target_q;
        state_d  = state_q;
        level_d  = level_q;
        timer_d  = timer_q;

        if (estop) begin
            state_d = S_ESTOP;
            level_d = 3'd0;
            timer_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (target_d != 3'd0) begin
                        state_d = S_RAMP_UP;
                        timer_d = '0;
                    end
                end
                S_HOLD: begin
                    if (target_d > level_q) begin
                        state_d = S_RAMP_UP;
                        timer_d = '0;
                    end else if (target_d < level_q) begin
                        state_d = S_RAMP_DOWN;
                        timer_d = '0;
                    end
                end
                S_RAMP_UP: begin
                    if (target_d == level_q) begin
                        state_d = (level_q == 3'd0) ? S_IDLE : S_HOLD;
                    end else if (target_d < level_q) begin
                        state_d = S_RAMP_DOWN;
                        timer_d = '0;
                    end else if (w_timer_tc && w_step_ok) begin
                        level_d = level_q + 3'd1;
                        timer_d = '0;
                        if (level_d == target_d) state_d = S_HOLD;
                    end else if (!w_timer_tc) begin
                        timer_d = TW'(timer_q + 1'b1);
                    end
                end
                S_RAMP_DOWN: begin
                    if (target_d == level_q) begin
                        state_d = (level_q == 3'd0) ? S_IDLE : S_HOLD;
                    end else if (target_d > level_q) begin
                        state_d = S_RAMP_UP;
                        timer_d = '0;
                    end else if (w_timer_tc && w_step_ok) begin
                        level_d = level_q - 3'd1;
                        timer_d = '0;
                        if (level_d == target_d) begin
                            state_d = (target_d == 3'd0) ? S_IDLE : S_HOLD;
                        end
                    end else if (!w_timer_tc) begin
                        timer_d = TW'(timer_q + 1'b1);
                    end
                end
                S_ESTOP: begin
                    level_d = 3'd0;
                    timer_d = '0;
                    if (target_d == 3'd0) state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                    level_d = 3'd0;
                    timer_d = '0;
                end
            endcase
        end

        speed_switch_d = encode(level_d);
        busy_d         = (state_d == S_RAMP_UP) || (state_d == S_RAMP_DOWN);
        fault_d        = (state_d == S_ESTOP);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            sw_q           <= 7'h7F;
            target_q       <= 3'd0;
            level_q        <= 3'd0;
            timer_q        <= '0;
            speed_switch_q <= 7'h7F;
            busy_q         <= 1'b0;
            fault_q        <= 1'b0;
            sw_err_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            sw_q           <= sw_d;
            target_q       <= target_d;
            level_q        <= level_d;
            timer_q        <= timer_d;
            speed_switch_q <= speed_switch_d;
            busy_q         <= busy_d;
            fault_q        <= fault_d;
            sw_err_q       <= sw_err_d;
        end
    end

    assign speed_switch = speed_switch_q;
    assign level        = level_q;
    assign busy         = busy_q;
    assign fault        = fault_q;
    assign sw_err       = sw_err_q;

endmodule
`default_nettype wire
